// File: rtl/screen_tracker.sv
// Tracks which vertically stacked screen the character occupies and runs the
// edge-crossing transition: reposition handshake, fade period, one settle frame.
module screen_tracker #(
    parameter int NUM_SCREENS       = 8,
    parameter int Y_TOP             = 0,
    parameter int Y_BOT             = 479,
    parameter int TRANSITION_FRAMES = 16
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [9:0] CharX,
    input  logic [9:0] CharY,
    input  logic [9:0] CharS,
    input  logic       reposition_ack,
    output logic [3:0] screen_idx,
    output logic [3:0] max_screen,
    output logic       reposition_req,
    output logic [9:0] reposition_y,
    output logic       transition_busy,
    output logic [7:0] fade_count,
    output logic       screen_changed
);
    typedef enum logic [1:0] {IDLE, REQ, FADE, SETTLE} state_t;

    localparam logic [10:0] YTOP   = 11'(Y_TOP);
    localparam logic [10:0] YBOT   = 11'(Y_BOT);
    localparam logic [3:0]  LAST   = 4'(NUM_SCREENS - 1);
    localparam logic [7:0]  FADE_N = 8'(TRANSITION_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] screen_idx_q, screen_idx_d;
    logic [3:0] max_screen_q, max_screen_d;
    logic [9:0] reposition_y_q, reposition_y_d;
    logic [7:0] fade_count_q, fade_count_d;
    logic       screen_changed_q, screen_changed_d;
    logic       top_hit, bot_hit;
    logic [10:0] cy, cs;

    // X position is carried for the character block but plays no part here.
    logic unused_charx;
    assign unused_charx = ^CharX;

    // 11-bit arithmetic so CharY + CharS cannot wrap.
    assign cy      = {1'b0, CharY};
    assign cs      = {1'b0, CharS};
    assign top_hit = (cy <= YTOP + cs);
    assign bot_hit = (cy + cs >= YBOT);

    always_comb begin
        state_d          = state_q;
        screen_idx_d     = screen_idx_q;
        max_screen_d     = max_screen_q;
        reposition_y_d   = reposition_y_q;
        fade_count_d     = fade_count_q;
        screen_changed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (top_hit && !bot_hit && screen_idx_q < LAST) begin
                        screen_idx_d     = screen_idx_q + 4'd1;
                        reposition_y_d   = 10'(YBOT - cs - 11'd1);
                        screen_changed_d = 1'b1;
                        state_d          = REQ;
                    end else if (bot_hit && !top_hit && screen_idx_q != 4'd0) begin
                        screen_idx_d     = screen_idx_q - 4'd1;
                        reposition_y_d   = 10'(YTOP + cs + 11'd1);
                        screen_changed_d = 1'b1;
                        state_d          = REQ;
                    end
                    if (screen_idx_d > max_screen_q)
                        max_screen_d = screen_idx_d;
                end
            end
            REQ: begin
                if (reposition_ack) begin
                    fade_count_d = 8'd0;
                    state_d      = FADE;
                end
            end
            FADE: begin
                if (frame_tick) begin
                    if (fade_count_q + 8'd1 >= FADE_N) begin
                        fade_count_d = 8'd0;
                        state_d      = SETTLE;
                    end else begin
                        fade_count_d = fade_count_q + 8'd1;
                    end
                end
            end
            SETTLE: begin
                if (frame_tick)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q          <= IDLE;
            screen_idx_q     <= 4'd0;
            max_screen_q     <= 4'd0;
            reposition_y_q   <= 10'd0;
            fade_count_q     <= 8'd0;
            screen_changed_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            screen_idx_q     <= screen_idx_d;
            max_screen_q     <= max_screen_d;
            reposition_y_q   <= reposition_y_d;
            fade_count_q     <= fade_count_d;
            screen_changed_q <= screen_changed_d;
        end
    end

    assign screen_idx      = screen_idx_q;
    assign max_screen      = max_screen_q;
    assign reposition_y    = reposition_y_q;
    assign fade_count      = fade_count_q;
    assign screen_changed  = screen_changed_q;
    assign reposition_req  = (state_q == REQ);
    assign transition_busy = (state_q != IDLE);
endmodule
